pcs_tx_ordered_set: RTL and testbench

Parametrised 1000BASE-X PCS transmit ordered-set generator, successor to the single-FSM transmit block. It sits between the GMII transmit interface and the 8b/10b encoder. It converts TXD/TX_EN/TX_ER into a registered code-group stream (/I/, /S/, /D/, /V/, /T/, /R/) and enforces:

- even/odd code-group alignment;
- TX_ER error propagation;
- a configurable minimum inter-packet idle;
- saturating packet and error counters.

---
 rtl/pcs_tx_ordered_set.sv | 172 +++++++++++++++++
 tb/tb_pcs_tx_ordered_set.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set generator: GMII TXD/TX_EN/TX_ER in,
// registered code-group stream (/I/ /S/ /D/ /V/ /T/ /R/) out, with idle spacing and counters.
module pcs_tx_ordered_set #(
  parameter logic [7:0] IDLE_D   = 8'h50,
  parameter int         MIN_IDLE = 1,
  parameter int         CNT_W    = 16
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic             xmit,
  input  logic             TX_EN,
  input  logic             TX_ER,
  input  logic [7:0]       TXD,
  input  logic             cnt_clr,
  output logic [7:0]       tx_code,
  output logic             tx_k,
  output logic [2:0]       tx_o_set,
  output logic             tx_even,
  output logic             transmitting,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] TX_TEST_XMIT = 3'd0;
  localparam logic [2:0] IDLE         = 3'd1;
  localparam logic [2:0] SOP          = 3'd2;
  localparam logic [2:0] DATA         = 3'd3;
  localparam logic [2:0] EOP_T        = 3'd4;
  localparam logic [2:0] EPD2         = 3'd5;
  localparam logic [2:0] EPD3         = 3'd6;

  localparam logic [2:0] OS_I = 3'd0;
  localparam logic [2:0] OS_S = 3'd1;
  localparam logic [2:0] OS_D = 3'd2;
  localparam logic [2:0] OS_T = 3'd3;
  localparam logic [2:0] OS_R = 3'd4;
  localparam logic [2:0] OS_V = 3'd5;

  localparam logic [3:0]       MIN_IDLE_L = 4'(MIN_IDLE);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic             even_q, even_d;
  logic [3:0]       idle_cnt_q, idle_cnt_d;
  logic             err_flag_q, err_flag_d;
  logic             abort_q, abort_d;
  logic [7:0]       code_q, code_d;
  logic             k_q, k_d;
  logic [2:0]       oset_q, oset_d;
  logic             txing_q, txing_d;
  logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q;
  logic             pkt_inc, err_inc;

  always_comb begin
    state_d    = state_q;
    even_d     = ~even_q;
    idle_cnt_d = idle_cnt_q;
    err_flag_d = err_flag_q;
    abort_d    = abort_q;

    case (state_q)
      TX_TEST_XMIT: begin
        if (xmit && even_d) begin
          state_d    = IDLE;
          idle_cnt_d = MIN_IDLE_L;
        end
      end
      IDLE: begin
        if (!xmit) begin
          state_d = TX_TEST_XMIT;
        end else if (!even_q && TX_EN && idle_cnt_q >= MIN_IDLE_L) begin
          state_d = SOP;
        end else if (!even_d && idle_cnt_q < MIN_IDLE_L) begin
          // an odd idle slot completes one idle ordered set
          idle_cnt_d = idle_cnt_q + 4'd1;
        end
      end
      SOP, DATA: begin
        if (!xmit) begin
          state_d = EOP_T;
          abort_d = 1'b1;
        end else if (TX_EN) begin
          state_d = DATA;
        end else begin
          state_d = EOP_T;
        end
      end
      EOP_T: state_d = EPD2;
      EPD2: begin
        if (!even_d)      state_d = EPD3;
        else if (abort_q) state_d = TX_TEST_XMIT;
        else              state_d = IDLE;
      end
      EPD3:    state_d = abort_q ? TX_TEST_XMIT : IDLE;
      default: state_d = TX_TEST_XMIT;
    endcase

    code_d  = even_d ? 8'hBC : IDLE_D;
    k_d     = even_d;
    oset_d  = OS_I;
    txing_d = 1'b1;
    pkt_inc = 1'b0;
    case (state_d)
      SOP: begin
        code_d     = 8'hFB; k_d = 1'b1; oset_d = OS_S;
        err_flag_d = 1'b0;
        abort_d    = 1'b0;
      end
      DATA: begin
        if (TX_ER) begin
          code_d = 8'hFE; k_d = 1'b1; oset_d = OS_V;
          err_flag_d = 1'b1;
        end else begin
          code_d = TXD; k_d = 1'b0; oset_d = OS_D;
        end
      end
      EOP_T: begin
        code_d     = 8'hFD; k_d = 1'b1; oset_d = OS_T;
        idle_cnt_d = 4'd0;
        pkt_inc    = 1'b1;
      end
      EPD2, EPD3: begin
        code_d = 8'hF7; k_d = 1'b1; oset_d = OS_R;
      end
      default: txing_d = 1'b0;
    endcase
    // abort_d covers a packet cut short in this very cycle
    err_inc = pkt_inc && (err_flag_q || abort_d);
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q    <= TX_TEST_XMIT;
      even_q     <= 1'b1;
      idle_cnt_q <= MIN_IDLE_L;
      err_flag_q <= 1'b0;
      abort_q    <= 1'b0;
      code_q     <= 8'hBC;
      k_q        <= 1'b1;
      oset_q     <= OS_I;
      txing_q    <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      even_q     <= even_d;
      idle_cnt_q <= idle_cnt_d;
      err_flag_q <= err_flag_d;
      abort_q    <= abort_d;
      code_q     <= code_d;
      k_q        <= k_d;
      oset_q     <= oset_d;
      txing_q    <= txing_d;
      if (cnt_clr) begin
        pkt_cnt_q <= '0;
        err_cnt_q <= '0;
      end else begin
        if (pkt_inc && !(&pkt_cnt_q)) pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
        if (err_inc && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + CNT_ONE;
      end
    end
  end

  assign tx_code      = code_q;
  assign tx_k         = k_q;
  assign tx_o_set     = oset_q;
  assign tx_even      = even_q;
  assign transmitting = txing_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Bench for pcs_tx_ordered_set: directed vector table from reset, a mid-packet
// reset, then random GMII traffic against a slot-level reference model.
module tb_pcs_tx_ordered_set;

  localparam int MIN_IDLE = 2;
  localparam int CNT_W    = 4;
  localparam int MAXC     = (1 << CNT_W) - 1;
  localparam int BIG_GAP  = 1000;

  logic             GTX_CLK = 1'b0;
  logic             mr_main_reset;
  logic             xmit, TX_EN, TX_ER, cnt_clr;
  logic [7:0]       TXD;
  logic [7:0]       tx_code;
  logic             tx_k, tx_even, transmitting;
  logic [2:0]       tx_o_set;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;

  pcs_tx_ordered_set #(.IDLE_D(8'h50), .MIN_IDLE(MIN_IDLE), .CNT_W(CNT_W)) dut (
    .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .xmit(xmit), .TX_EN(TX_EN),
    .TX_ER(TX_ER), .TXD(TXD), .cnt_clr(cnt_clr), .tx_code(tx_code), .tx_k(tx_k),
    .tx_o_set(tx_o_set), .tx_even(tx_even), .transmitting(transmitting),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit x, en, er; logic [7:0] d; bit clr;
    logic [7:0] code; bit k; logic [2:0] os; bit ev; bit tx; int pk; int ec;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(bit x, bit en, bit er, logic [7:0] d, bit clr,
                              logic [7:0] code, bit k, logic [2:0] os, bit ev, bit tx, int pk, int ec);
    vec_t v;
    v.x = x; v.en = en; v.er = er; v.d = d; v.clr = clr;
    v.code = code; v.k = k; v.os = os; v.ev = ev; v.tx = tx; v.pk = pk; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] code, input bit k, input logic [2:0] os,
                       input bit ev, input bit tx, input int pk, input int ec);
    n_vec++;
    if (tx_code !== code || tx_k !== k || tx_o_set !== os || tx_even !== ev ||
        transmitting !== tx || pkt_cnt !== CNT_W'(pk) || err_cnt !== CNT_W'(ec)) begin
      n_err++;
      $display("FAIL %s: got code=%h k=%b os=%0d even=%b tx=%b pkt=%0d err=%0d, want code=%h k=%b os=%0d even=%b tx=%b pkt=%0d err=%0d",
               name, tx_code, tx_k, tx_o_set, tx_even, transmitting, pkt_cnt, err_cnt,
               code, k, os, ev, tx, pk, ec);
    end
  endtask

  // Reference model: tracks the kind of slot on the wire and the idle gap in slots.
  int         m_kind;  // 0 idle, 1 S, 2 D, 3 T, 4 R, 5 V
  bit         m_even, m_link, m_rfirst, m_perr, m_abort;
  int         m_gap, m_pkt, m_err;
  logic [7:0] m_d;

  task automatic model_reset();
    m_kind = 0; m_even = 1; m_link = 0; m_rfirst = 0; m_perr = 0; m_abort = 0;
    m_gap = BIG_GAP; m_pkt = 0; m_err = 0; m_d = 8'h00;
  endtask

  task automatic model_step(input bit x, input bit en, input bit er, input logic [7:0] d, input bit clr);
    bit ne;
    int k;
    ne = !m_even;
    k  = 0;
    case (m_kind)
      1, 2, 5: begin
        if (!x) begin k = 3; m_abort = 1; end
        else if (en) k = er ? 5 : 2;
        else k = 3;
      end
      3: begin k = 4; m_rfirst = 1; end
      4: begin
        if (m_rfirst && !ne) begin k = 4; m_rfirst = 0; end
        else if (m_abort) m_link = 0;
        else begin m_link = 1; m_gap = 0; end
      end
      default: begin
        if (!m_link) begin
          if (x && ne) begin m_link = 1; m_gap = BIG_GAP; end
        end else if (!x) m_link = 0;
        else if (ne && en && m_gap >= 2 * MIN_IDLE) k = 1;
      end
    endcase
    if (k == 0 && m_link && m_gap < BIG_GAP) m_gap++;
    if (k == 1) begin m_perr = 0; m_abort = 0; end
    if (k == 5) m_perr = 1;
    if (k == 3 && !clr) begin
      if (m_pkt < MAXC) m_pkt++;
      if ((m_perr || m_abort) && m_err < MAXC) m_err++;
    end
    if (clr) begin m_pkt = 0; m_err = 0; end
    m_even = ne; m_kind = k; m_d = d;
  endtask

  task automatic model_check(input string name);
    logic [7:0] c; bit kk; logic [2:0] os;
    case (m_kind)
      1: begin c = 8'hFB; kk = 1; os = 3'd1; end
      2: begin c = m_d;   kk = 0; os = 3'd2; end
      3: begin c = 8'hFD; kk = 1; os = 3'd3; end
      4: begin c = 8'hF7; kk = 1; os = 3'd4; end
      5: begin c = 8'hFE; kk = 1; os = 3'd5; end
      default: begin c = m_even ? 8'hBC : 8'h50; kk = m_even; os = 3'd0; end
    endcase
    check(name, c, kk, os, m_even, m_kind != 0, m_pkt, m_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rx, ren;
    // x en er d clr | code k os even tx pkt err
    vq.push_back(mk(1,0,0,8'h00,0, 8'h50,0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hBC,1,0,1,0,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'h50,0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hBC,1,0,1,0,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'h50,0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hBC,1,0,1,0,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'h50,0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hBC,1,0,1,0,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'h50,0,0,0,0,0,0));
    vq.push_back(mk(1,1,0,8'h11,0, 8'hFB,1,1,1,1,0,0));  // even-aligned packet
    vq.push_back(mk(1,1,0,8'h22,0, 8'h22,0,2,0,1,0,0));
    vq.push_back(mk(1,1,0,8'h33,0, 8'h33,0,2,1,1,0,0));
    vq.push_back(mk(1,1,0,8'h44,0, 8'h44,0,2,0,1,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hFD,1,3,1,1,1,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hF7,1,4,0,1,1,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hBC,1,0,1,0,1,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'h50,0,0,0,0,1,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hBC,1,0,1,0,1,0));
    vq.push_back(mk(1,1,0,8'h11,0, 8'h50,0,0,0,0,1,0));  // odd-aligned start, octet dropped
    vq.push_back(mk(1,1,0,8'h22,0, 8'hFB,1,1,1,1,1,0));
    vq.push_back(mk(1,1,0,8'h33,0, 8'h33,0,2,0,1,1,0));
    vq.push_back(mk(1,1,0,8'h44,0, 8'h44,0,2,1,1,1,0));
    vq.push_back(mk(1,0,0,8'h00,1, 8'hFD,1,3,0,1,0,0));  // clear beats increment
    vq.push_back(mk(1,0,0,8'h00,0, 8'hF7,1,4,1,1,0,0));
    vq.push_back(mk(1,1,0,8'h00,0, 8'hF7,1,4,0,1,0,0));  // TX_EN during /R/ ignored
    vq.push_back(mk(1,1,0,8'h00,0, 8'hBC,1,0,1,0,0,0));
    vq.push_back(mk(1,1,0,8'h00,0, 8'h50,0,0,0,0,0,0));
    vq.push_back(mk(1,1,0,8'h00,0, 8'hBC,1,0,1,0,0,0));
    vq.push_back(mk(1,1,0,8'h00,0, 8'h50,0,0,0,0,0,0));
    vq.push_back(mk(1,1,0,8'hAA,0, 8'hFB,1,1,1,1,0,0));
    vq.push_back(mk(1,1,0,8'hBB,0, 8'hBB,0,2,0,1,0,0));
    vq.push_back(mk(1,1,1,8'hCC,0, 8'hFE,1,5,1,1,0,0));  // TX_ER -> /V/
    vq.push_back(mk(1,1,0,8'hDD,0, 8'hDD,0,2,0,1,0,0));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hFD,1,3,1,1,1,1));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hF7,1,4,0,1,1,1));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hBC,1,0,1,0,1,1));
    vq.push_back(mk(1,1,0,8'h00,0, 8'h50,0,0,0,0,1,1));
    vq.push_back(mk(1,1,0,8'h00,0, 8'hBC,1,0,1,0,1,1));
    vq.push_back(mk(1,1,0,8'h00,0, 8'h50,0,0,0,0,1,1));
    vq.push_back(mk(1,1,0,8'h01,0, 8'hFB,1,1,1,1,1,1));
    vq.push_back(mk(1,1,0,8'h02,0, 8'h02,0,2,0,1,1,1));
    vq.push_back(mk(0,1,0,8'h03,0, 8'hFD,1,3,1,1,2,2));  // xmit drop mid-DATA
    vq.push_back(mk(0,1,0,8'h00,0, 8'hF7,1,4,0,1,2,2));
    vq.push_back(mk(0,1,0,8'h00,0, 8'hBC,1,0,1,0,2,2));
    vq.push_back(mk(0,1,0,8'h00,0, 8'h50,0,0,0,0,2,2));
    vq.push_back(mk(1,1,0,8'h00,0, 8'hBC,1,0,1,0,2,2));
    vq.push_back(mk(1,1,0,8'h00,0, 8'h50,0,0,0,0,2,2));
    vq.push_back(mk(1,1,0,8'h55,0, 8'hFB,1,1,1,1,2,2));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hFD,1,3,0,1,3,2));  // minimum packet
    vq.push_back(mk(1,0,0,8'h00,0, 8'hF7,1,4,1,1,3,2));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hF7,1,4,0,1,3,2));
    vq.push_back(mk(1,0,0,8'h00,0, 8'hBC,1,0,1,0,3,2));
    vq.push_back(mk(1,0,0,8'h00,0, 8'h50,0,0,0,0,3,2));
    vq.push_back(mk(1,1,0,8'h00,0, 8'hBC,1,0,1,0,3,2));
    vq.push_back(mk(1,1,0,8'h00,0, 8'h50,0,0,0,0,3,2));
    vq.push_back(mk(1,1,0,8'h66,0, 8'hFB,1,1,1,1,3,2));
    vq.push_back(mk(1,1,0,8'h77,0, 8'h77,0,2,0,1,3,2));

    mr_main_reset = 1'b0;
    xmit = 1'b1; TX_EN = 1'b0; TX_ER = 1'b0; TXD = 8'h00; cnt_clr = 1'b0;
    repeat (2) @(posedge GTX_CLK);
    #1;
    check("reset", 8'hBC, 1, 3'd0, 1, 0, 0, 0);
    mr_main_reset = 1'b1;

    foreach (vq[i]) begin
      xmit = vq[i].x; TX_EN = vq[i].en; TX_ER = vq[i].er; TXD = vq[i].d; cnt_clr = vq[i].clr;
      @(posedge GTX_CLK);
      #1;
      check($sformatf("vec%0d", i + 1), vq[i].code, vq[i].k, vq[i].os, vq[i].ev, vq[i].tx, vq[i].pk, vq[i].ec);
    end

    // reset mid-packet: outputs return to reset values without waiting for a clock
    mr_main_reset = 1'b0;
    #2;
    check("reset_mid_pkt", 8'hBC, 1, 3'd0, 1, 0, 0, 0);
    xmit = 1'b1; TX_EN = 1'b0; TX_ER = 1'b0; cnt_clr = 1'b0;
    @(posedge GTX_CLK);
    #1;
    mr_main_reset = 1'b1;
    model_reset();

    rx = 1'b1; ren = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        mr_main_reset = 1'b0;
        #1;
        model_reset();
        model_check("rand_reset");
        mr_main_reset = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) rx = !rx;
      if ($urandom_range(0, 4) == 0) ren = !ren;
      xmit = rx; TX_EN = ren;
      TX_ER   = ($urandom_range(0, 11) == 0);
      TXD     = 8'($urandom);
      cnt_clr = ($urandom_range(0, 399) == 0);
      model_step(xmit, TX_EN, TX_ER, TXD, cnt_clr);
      @(posedge GTX_CLK);
      #1;
      model_check($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
